// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the ID/EX control pipeline:
// opcodes, ALUOp encoding, the control bundle and its NOP value.
package riscv_ctrl_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    reg_write;
        logic    branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        alu_op:     ALUOP_ADD,
        alu_src:    1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        reg_write:  1'b0,
        branch:     1'b0
    };

endpackage

// File: rtl/id_ex_control_pipe_imm_gen.sv
// imm_gen: combinational I/S/B immediate select with sign extension.
// Ports: i_opcode, i_hi = instr[31:20], i_lo = instr[11:7]; o_imm.
module imm_gen
    import riscv_ctrl_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [6:0]  i_opcode,
    input  logic [11:0] i_hi,
    input  logic [4:0]  i_lo,
    output logic [W-1:0] o_imm
);

    always_comb begin
        o_imm = '0;
        case (i_opcode)
            OP_LOAD:   o_imm = {{(W-12){i_hi[11]}}, i_hi};
            OP_STORE:  o_imm = {{(W-12){i_hi[11]}}, i_hi[11:5], i_lo};
            // B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
            OP_BRANCH: o_imm = {{(W-12){i_hi[11]}}, i_lo[0],
                                i_hi[10:5], i_lo[4:1], 1'b0};
            default:   o_imm = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_control_pipe.sv
// ID-stage main decoder plus the ID/EX control pipeline register.
// Inputs: clk, reset (async, active-high), id_instr, id_valid, stall,
// flush, ex_hold. Outputs: ex_valid, ex_ALUOp, ex_funct3,
// ex_funct7_bit_6, controls, ex_rs1/rs2/rd, ex_imm, and ex_illegal
// when ILLEGAL_INSTR_EN is defined.
module id_ex_control_pipe
    import riscv_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       id_instr,
    input  logic              id_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              ex_valid,
    output logic [1:0]        ex_ALUOp,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7_bit_6,
    output logic              ex_alu_src,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_reg_write,
    output logic              ex_branch,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
`ifdef ILLEGAL_INSTR_EN
    output logic              ex_illegal,
`endif
    output logic [XLEN-1:0]   ex_imm
);

    logic [6:0]      w_opcode;
    logic            w_is_r;
    logic            w_is_ld;
    logic            w_is_st;
    logic            w_is_br;
    logic            w_load;
    ctrl_t           w_ctrl;
    logic [XLEN-1:0] w_imm;

    ctrl_t           r_ctrl;
    logic            r_valid;
    logic [2:0]      r_funct3;
    logic            r_f7b;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic [XLEN-1:0] r_imm;

    assign w_opcode = id_instr[6:0];
    assign w_is_r   = (w_opcode == OP_R);
    assign w_is_ld  = (w_opcode == OP_LOAD);
    assign w_is_st  = (w_opcode == OP_STORE);
    assign w_is_br  = (w_opcode == OP_BRANCH);
    assign w_load   = id_valid && !stall;

    imm_gen #(.W(XLEN)) u_imm_gen (
        .i_opcode (w_opcode),
        .i_hi     (id_instr[31:20]),
        .i_lo     (id_instr[11:7]),
        .o_imm    (w_imm)
    );

`ifdef ILLEGAL_INSTR_EN
    logic w_r_legal;
    logic w_illegal;
    logic r_illegal;

    // Only add, sub, and, or are implemented among R-type encodings.
    assign w_r_legal =
        ({id_instr[31:25], id_instr[14:12]} == {7'h00, 3'b000}) ||
        ({id_instr[31:25], id_instr[14:12]} == {7'h20, 3'b000}) ||
        ({id_instr[31:25], id_instr[14:12]} == {7'h00, 3'b111}) ||
        ({id_instr[31:25], id_instr[14:12]} == {7'h00, 3'b110});
    assign w_illegal = !(w_is_ld || w_is_st || w_is_br)
                       && !(w_is_r && w_r_legal);
`endif

    always_comb begin
        w_ctrl = CTRL_NOP;
        unique case (1'b1)
            w_is_r: begin
                w_ctrl.alu_op    = ALUOP_FUNCT;
                w_ctrl.reg_write = 1'b1;
            end
            w_is_ld: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            w_is_st: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            w_is_br: begin
                w_ctrl.alu_op = ALUOP_SUB;
                w_ctrl.branch = 1'b1;
            end
            default: w_ctrl = CTRL_NOP;
        endcase
`ifdef ILLEGAL_INSTR_EN
        if (w_illegal)
            w_ctrl = CTRL_NOP;
`endif
    end

    // Flush beats hold; hold beats stall. Bubbles still carry the
    // instruction fields, only controls and valid are cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_ctrl   <= CTRL_NOP;
            r_funct3 <= '0;
            r_f7b    <= 1'b0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rd     <= '0;
            r_imm    <= '0;
        end else if (flush || !ex_hold) begin
            r_valid  <= w_load && !flush;
            r_ctrl   <= (w_load && !flush) ? w_ctrl : CTRL_NOP;
            r_funct3 <= id_instr[14:12];
            r_f7b    <= id_instr[30];
            r_rs1    <= id_instr[19:15];
            r_rs2    <= id_instr[24:20];
            r_rd     <= id_instr[11:7];
            r_imm    <= w_imm;
        end
    end

`ifdef ILLEGAL_INSTR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_illegal <= 1'b0;
        else if (flush || !ex_hold)
            r_illegal <= w_load && !flush && w_illegal;
    end

    assign ex_illegal = r_illegal;
`endif

    assign ex_valid        = r_valid;
    assign ex_ALUOp        = r_ctrl.alu_op;
    assign ex_alu_src      = r_ctrl.alu_src;
    assign ex_mem_read     = r_ctrl.mem_read;
    assign ex_mem_write    = r_ctrl.mem_write;
    assign ex_mem_to_reg   = r_ctrl.mem_to_reg;
    assign ex_reg_write    = r_ctrl.reg_write;
    assign ex_branch       = r_ctrl.branch;
    assign ex_funct3       = r_funct3;
    assign ex_funct7_bit_6 = r_f7b;
    assign ex_rs1          = r_rs1;
    assign ex_rs2          = r_rs2;
    assign ex_rd           = r_rd;
    assign ex_imm          = r_imm;

endmodule

// File: tb/tb_id_ex_control_pipe.sv
// Randomized and directed bench for id_ex_control_pipe against a
// behavioural model of the decode and pipeline-register rules.
module tb_id_ex_control_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_instr;
    logic        id_valid, stall, flush, ex_hold;
    logic        ex_valid;
    logic [1:0]  ex_ALUOp;
    logic [2:0]  ex_funct3;
    logic        ex_funct7_bit_6;
    logic        ex_alu_src, ex_mem_read, ex_mem_write;
    logic        ex_mem_to_reg, ex_reg_write, ex_branch;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_imm;
`ifdef ILLEGAL_INSTR_EN
    logic        ex_illegal;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic        m_valid;
    logic [1:0]  m_op;
    logic [5:0]  m_ctl; // alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch
    logic [2:0]  m_f3;
    logic        m_f7b;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_imm;
    logic        m_ill;

    always #5 clk = ~clk;

    id_ex_control_pipe dut (
        .clk             (clk),
        .reset           (reset),
        .id_instr        (id_instr),
        .id_valid        (id_valid),
        .stall           (stall),
        .flush           (flush),
        .ex_hold         (ex_hold),
        .ex_valid        (ex_valid),
        .ex_ALUOp        (ex_ALUOp),
        .ex_funct3       (ex_funct3),
        .ex_funct7_bit_6 (ex_funct7_bit_6),
        .ex_alu_src      (ex_alu_src),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_reg_write    (ex_reg_write),
        .ex_branch       (ex_branch),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_rd           (ex_rd),
`ifdef ILLEGAL_INSTR_EN
        .ex_illegal      (ex_illegal),
`endif
        .ex_imm          (ex_imm)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] obs();
        return {4'h0, ex_valid, ex_ALUOp, ex_funct3, ex_funct7_bit_6,
                ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                ex_reg_write, ex_branch, ex_rs1, ex_rs2, ex_rd, ex_imm};
    endfunction

    function automatic logic [63:0] want();
        return {4'h0, m_valid, m_op, m_f3, m_f7b, m_ctl,
                m_rs1, m_rs2, m_rd, m_imm};
    endfunction

    // Reference decode: what an instruction means, independent of pipeline.
    task automatic ref_decode(input logic [31:0] ins,
                              output logic [1:0] op,
                              output logic [5:0] ctl,
                              output logic [31:0] imm,
                              output logic ill);
        int sx;
        logic [9:0] fk;
        op  = 2'b00;
        ctl = 6'b0;
        imm = 32'd0;
        ill = 1'b0;
        fk  = {ins[31:25], ins[14:12]};
        case (ins[6:0])
            7'b0110011: begin
                op = 2'b10; ctl = 6'b000010;
                ill = !(fk == 10'h000 || fk == 10'h100 ||
                        fk == 10'h007 || fk == 10'h006);
            end
            7'b0000011: begin
                op = 2'b00; ctl = 6'b110110;
                sx = int'($signed(ins[31:20]));
                imm = 32'(sx);
            end
            7'b0100011: begin
                op = 2'b00; ctl = 6'b101000;
                sx = int'($signed({ins[31:25], ins[11:7]}));
                imm = 32'(sx);
            end
            7'b1100011: begin
                op = 2'b01; ctl = 6'b000001;
                sx = int'($signed({ins[31], ins[7], ins[30:25],
                                   ins[11:8], 1'b0}));
                imm = 32'(sx);
            end
            default: ill = 1'b1;
        endcase
`ifdef ILLEGAL_INSTR_EN
        if (ill) begin
            op = 2'b00; ctl = 6'b0;
        end
`endif
    endtask

    task automatic mdl_clock();
        logic [1:0]  op;
        logic [5:0]  ctl;
        logic [31:0] imm;
        logic        ill, live;
        if (ex_hold && !flush)
            return;
        ref_decode(id_instr, op, ctl, imm, ill);
        live    = id_valid && !stall && !flush;
        m_valid = live;
        m_op    = live ? op : 2'b00;
        m_ctl   = live ? ctl : 6'b0;
        m_ill   = live && ill;
        m_f3    = id_instr[14:12];
        m_f7b   = id_instr[30];
        m_rs1   = id_instr[19:15];
        m_rs2   = id_instr[24:20];
        m_rd    = id_instr[11:7];
        m_imm   = imm;
    endtask

    task automatic mdl_reset();
        m_valid = 0; m_op = 0; m_ctl = 0; m_f3 = 0; m_f7b = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_imm = 0; m_ill = 0;
    endtask

    // Inputs applied at the negedge, DUT compared at the next negedge.
    task automatic step(input string tag, input logic [31:0] ins,
                        input logic v, input logic st,
                        input logic fl, input logic hd);
        id_instr = ins; id_valid = v; stall = st;
        flush = fl; ex_hold = hd;
        @(posedge clk);
        mdl_clock();
        @(negedge clk);
        chk(tag, obs(), want());
`ifdef ILLEGAL_INSTR_EN
        chk({tag, "_ill"}, {63'd0, ex_illegal}, {63'd0, m_ill});
`endif
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        logic [6:0]  ops [5];
        r = $urandom;
        ops[0] = 7'b0110011; ops[1] = 7'b0000011;
        ops[2] = 7'b0100011; ops[3] = 7'b1100011;
        ops[4] = 7'($urandom);
        r[6:0] = ops[$urandom_range(0, 4)];
        if (r[6:0] == 7'b0110011 && $urandom_range(0, 2) != 0)
            r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        id_instr = 32'd0; id_valid = 0; stall = 0; flush = 0; ex_hold = 0;
        mdl_reset();
        #12;
        chk("reset_state", obs(), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // add x3,x1,x2
        step("add", 32'h002081B3, 1, 0, 0, 0);
        chk("add_fields",
            {ex_valid, ex_ALUOp, ex_funct3, ex_funct7_bit_6,
             ex_reg_write, ex_rd},
            {1'b1, 2'b10, 3'b000, 1'b0, 1'b1, 5'd3});

        // lw x5,-4(x2)
        step("lw", 32'hFFC12283, 1, 0, 0, 0);
        chk("lw_fields",
            {ex_ALUOp, ex_alu_src, ex_mem_read, ex_mem_to_reg, ex_imm},
            {2'b00, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFC});

        // beq x1,x2,+8 stalled, then released
        step("beq_stall", 32'h00208463, 1, 1, 0, 0);
        chk("beq_bubble", {ex_valid, ex_ALUOp, ex_branch, ex_reg_write},
            5'b0);
        step("beq_go", 32'h00208463, 1, 0, 0, 0);
        chk("beq_fields", {ex_valid, ex_ALUOp, ex_branch, ex_imm},
            {1'b1, 2'b01, 1'b1, 32'd8});

        // sub x3,x1,x2 then hold with changing IDs
        step("sub", 32'h402081B3, 1, 0, 0, 0);
        step("hold0", 32'hFFC12283, 1, 0, 0, 1);
        step("hold1", 32'h00208463, 1, 1, 0, 1);
        step("hold2", 32'h002081B3, 0, 0, 0, 1);
        chk("hold_frozen", {ex_valid, ex_ALUOp, ex_funct7_bit_6, ex_rd},
            {1'b1, 2'b10, 1'b1, 5'd3});
        step("flush_hold", 32'h002081B3, 1, 0, 1, 1);
        chk("flush_bubble", {ex_valid, ex_ALUOp, ex_reg_write}, 4'b0);

        // unsupported opcode
        step("op7f", 32'h0000007F, 1, 0, 0, 0);
`ifdef ILLEGAL_INSTR_EN
        chk("op7f_ill", {ex_valid, ex_illegal, ex_reg_write}, 3'b110);
`else
        chk("op7f_nop", {ex_valid, ex_ALUOp, ex_reg_write, ex_alu_src},
            5'b10000);
`endif

        // async reset during a hold, between edges
        step("pre_rst", 32'hFFC12283, 1, 0, 0, 0);
        ex_hold = 1'b1;
        #2 reset = 1'b1;
        #1;
        mdl_reset();
        chk("async_reset", obs(), 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_hold", obs(), 64'd0);
        step("post_rst", 32'h002081B3, 1, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", rnd_instr(), 1'($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
